// File: rtl/nice_icb_mem_responder.sv
// NICE ICB memory target: byte-masked word SRAM, fixed response latency, bounded outstanding.
// Optional NICE_ICB_MEM_STALL_EN adds LFSR-driven pseudo-random command stalls.
module nice_icb_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int RSP_LAT = 2,
  parameter int OUTS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [ADDR_W-1:0] icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [MW-1:0]     icb_cmd_wmask,
  input  logic [1:0]        icb_cmd_size,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic              icb_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int EW = DW + 1;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0] OUTS_MAX = CW'(OUTS_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTS_DEPTH - 1);

  logic [DW-1:0]     mem [DEPTH_WORDS];
  logic [CW-1:0]     outs_cnt;
  logic              stall;
  logic              cmd_hs;
  logic              rsp_hs;
  logic [ADDR_W-1:0] addr_off;
  logic              addr_err;
  logic [AW-1:0]     widx;
  logic [EW-1:0]     ent_in;
  logic [EW-1:0]     ent_push;
  logic              push;
  logic [EW-1:0]     fifo [OUTS_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     fcnt;
  logic [EW-1:0]     ent_out;

`ifdef NICE_ICB_MEM_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Credit check covers delay line plus FIFO, so the FIFO never overflows.
  assign icb_cmd_ready = !rst && (outs_cnt < OUTS_MAX) && !stall;
  assign cmd_hs = icb_cmd_valid && icb_cmd_ready;
  assign rsp_hs = icb_rsp_valid && icb_rsp_ready;

  assign addr_off = icb_cmd_addr - BASE_ADDR;
  assign addr_err = (icb_cmd_addr < BASE_ADDR)
                 || ({1'b0, addr_off} >= MEM_BYTES)
                 || (icb_cmd_addr[1:0] != 2'b00)
                 || (icb_cmd_size != 2'b10);
  assign widx = addr_off[AW+1:2];

  always_comb begin
    ent_in = '0;
    ent_in[DW] = addr_err;
    if (icb_cmd_read && !addr_err) ent_in[DW-1:0] = mem[widx];
  end

  always_ff @(posedge clk) begin
    if (cmd_hs && !icb_cmd_read && !addr_err) begin
      for (int i = 0; i < MW; i++) begin
        if (icb_cmd_wmask[i]) mem[widx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
      end
    end
  end

  // Delay line holds RSP_LAT-1 registers; the FIFO write adds the last cycle.
  if (RSP_LAT == 1) begin : g_nodl
    assign push = cmd_hs;
    assign ent_push = ent_in;
  end else begin : g_dl
    logic [RSP_LAT-2:0] dl_v;
    logic [EW-1:0]      dl_d [RSP_LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        dl_v <= '0;
      end else begin
        dl_v[0] <= cmd_hs;
        for (int i = 1; i < RSP_LAT - 1; i++) dl_v[i] <= dl_v[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dl_d[0] <= ent_in;
      for (int i = 1; i < RSP_LAT - 1; i++) dl_d[i] <= dl_d[i-1];
    end

    assign push = dl_v[RSP_LAT-2];
    assign ent_push = dl_d[RSP_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= ent_push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      fcnt     <= '0;
      outs_cnt <= '0;
    end else begin
      if (push)   wp <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
      if (rsp_hs) rp <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
      fcnt     <= fcnt + CW'(push) - CW'(rsp_hs);
      outs_cnt <= outs_cnt + CW'(cmd_hs) - CW'(rsp_hs);
    end
  end

  assign ent_out = fifo[rp];
  assign icb_rsp_valid = !rst && (fcnt != '0);
  assign icb_rsp_rdata = icb_rsp_valid ? ent_out[DW-1:0] : '0;
  assign icb_rsp_err = icb_rsp_valid ? ent_out[DW] : 1'b0;

endmodule
